uart_rx_oversampled: RTL and testbench

- UART receiver that converts the asynchronous `rx` pin into parallel bytes.
- Sits directly upstream of the RX FIFO, which feeds the command controller in the counter/FND design.
- Uses 16x oversampling with mid-bit sampling.
- Emits a one-cycle `rx_done` strobe per valid frame and flags framing errors.
- Frame format: 8N1 (8 data bits, no parity, 1 stop bit), LSB first.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/baud_tick_gen.sv | 30 +++
 rtl/uart_rx_oversampled.sv | 137 +++++++++++++
 tb/tb_uart_rx_oversampled.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART blocks: receiver FSM states,
// frame geometry and the baud tick divider calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_OVERSAMPLE = 16;

  // Clock cycles per oversample tick (integer division, truncating).
  function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                       input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// Only rst clears it, so the receiver and transmitter can share one tick timebase.
module baud_tick_gen #(
  parameter int TICK_DIV = 651
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CNT_MAX);
  assign tick     = w_at_max;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_at_max) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 8N1 UART receiver with 16x oversampling: starts on a falling edge, checks the
// start bit at its midpoint, then samples each data and stop bit one bit period apart.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_done,
  output logic                      rx_busy,
  output logic                      frame_err,
  output uart_rx_state_t            dbg_state
);

  // Handshake: rx_done is a one-cycle valid strobe with rx_data valid in the
  // same cycle; there is no ready, so the consumer must take every strobe.
  localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] SMP_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

  logic r_rx_meta, r_rx_s;
  logic w_tick;

  uart_rx_state_t            r_state, w_state_nxt;
  logic [SW-1:0]             r_smp_cnt, w_smp_nxt;
  logic [2:0]                r_bit_cnt, w_bit_nxt;
  logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [UART_DATA_BITS-1:0] r_rx_data, w_data_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_ferr, w_ferr_nxt;

  baud_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_state   <= IDLE;
      r_smp_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_rx_data <= '0;
      r_done    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_state   <= w_state_nxt;
      r_smp_cnt <= w_smp_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_rx_data <= w_data_nxt;
      r_done    <= w_done_nxt;
      r_ferr    <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_smp_nxt   = r_smp_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_rx_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = START;
          w_smp_nxt   = '0;
        end
      end
      START: begin
        if (w_tick) begin
          if (r_smp_cnt == SMP_MID) begin
            if (r_rx_s) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = DATA;
              w_smp_nxt   = '0;
              w_bit_nxt   = '0;
            end
          end else begin
            w_smp_nxt = r_smp_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_smp_cnt == SMP_LAST) begin
            w_smp_nxt   = '0;
            w_shift_nxt = {r_rx_s, r_shift[UART_DATA_BITS-1:1]};
            w_bit_nxt   = r_bit_cnt + 3'd1;
            if (r_bit_cnt == BIT_LAST) w_state_nxt = STOP;
          end else begin
            w_smp_nxt = r_smp_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        // Leaving at mid-stop gives half a bit of margin for a back-to-back start edge.
        if (w_tick) begin
          if (r_smp_cnt == SMP_LAST) begin
            w_state_nxt = IDLE;
            if (r_rx_s) begin
              w_data_nxt = r_shift;
              w_done_nxt = 1'b1;
            end else begin
              w_ferr_nxt = 1'b1;
            end
          end else begin
            w_smp_nxt = r_smp_cnt + SW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_data   = r_rx_data;
  assign rx_done   = r_done;
  assign frame_err = r_ferr;
  assign rx_busy   = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled: directed frames push expected
// {frame_err, rx_data} entries, a monitor pops them on each output strobe.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;
  import uart_pkg::*;

  // 625 kbaud at 100 MHz gives TICK_DIV = 10, a 160-clock bit.
  localparam int CLK_FREQ  = 100_000_000;
  localparam int BAUD_RATE = 625_000;
  localparam int BIT_CLKS  = 160;
  localparam int BIT_NS    = 1600;
  localparam int TICK_NS   = 100;

  logic           clk;
  logic           rst;
  logic           rx;
  logic [7:0]     rx_data;
  logic           rx_done;
  logic           rx_busy;
  logic           frame_err;
  uart_rx_state_t dbg_state;

  logic [8:0] exp_q[$];
  time        done_t[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  uart_rx_oversampled #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no completion, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drivers
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bit_ns);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_b;
    // A low stop bit is released early so the start it re-triggers is rejected cleanly.
    if (stop_b) #(bit_ns);
    else #(bit_ns * 3 / 4);
    rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    repeat (n * BIT_CLKS) @(posedge clk);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_done && frame_err) check("done_ferr_exclusive", 32'd1, 32'd0);
      if (rx_done || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {23'd0, frame_err, rx_data}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("strobe_ferr_data", {23'd0, frame_err, rx_data}, {23'd0, e});
        end
        if (rx_done) begin
          check("busy_low_at_done", {31'd0, rx_busy}, 32'd0);
          done_t.push_back($time);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_rx_data", {24'd0, rx_data}, 32'h00);
    check("rst_rx_done", {31'd0, rx_done}, 32'd0);
    check("rst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    rst = 1'b0;
    idle_bits(1);

    // Single byte 'R'
    exp_q.push_back({1'b0, 8'h52});
    send_frame(8'h52, 1'b1, BIT_NS);
    idle_bits(2);

    // Glitch rejection
    @(negedge clk);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    rx = 1'b1;
    repeat (85) @(negedge clk);
    check("glitch_state_idle", {30'd0, dbg_state}, {30'd0, IDLE});
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    idle_bits(1);

    // Framing error: rx_data must hold 0x52
    exp_q.push_back({1'b1, 8'h52});
    send_frame(8'h43, 1'b0, BIT_NS);
    idle_bits(2);

    // Back-to-back 'C' then 'M'
    exp_q.push_back({1'b0, 8'h43});
    exp_q.push_back({1'b0, 8'h4D});
    send_frame(8'h43, 1'b1, BIT_NS);
    send_frame(8'h4D, 1'b1, BIT_NS);
    idle_bits(1);
    if (done_t.size() < 2) begin
      check("b2b_done_count", done_t.size(), 32'd2);
    end else begin
      longint diff, err;
      diff = longint'(done_t[done_t.size()-1] - done_t[done_t.size()-2]);
      err  = diff - 10 * BIT_NS;
      if (err < 0) err = -err;
      check("b2b_spacing_in_tol", {31'd0, err <= TICK_NS}, 32'd1);
    end
    idle_bits(1);

    // Reset mid-frame after start plus 4 data bits of 0xFF
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(4 * BIT_NS);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_rx_data", {24'd0, rx_data}, 32'h00);
    check("midrst_rx_done", {31'd0, rx_done}, 32'd0);
    check("midrst_rx_busy", {31'd0, rx_busy}, 32'd0);
    check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, {30'd0, IDLE});
    idle_bits(6);

    exp_q.push_back({1'b0, 8'h61});
    send_frame(8'h61, 1'b1, BIT_NS);
    idle_bits(2);

    // Baud tolerance +2% / -2%
    exp_q.push_back({1'b0, 8'h63});
    send_frame(8'h63, 1'b1, BIT_NS * 102 / 100);
    idle_bits(2);
    exp_q.push_back({1'b0, 8'h63});
    send_frame(8'h63, 1'b1, BIT_NS * 98 / 100);
    idle_bits(2);

    begin
      int budget;
      budget = 4 * BIT_CLKS;
      while (exp_q.size() != 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    check("total_done_pulses", done_t.size(), 32'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
